// File: rtl/button_conditioner_if.sv
// Button conditioner pin bundle.
// Raw buttons flow toward the conditioner; conditioned pulses flow back out.
//   btn_init, btn_inc, btn_dec : raw asynchronous active-high push buttons
//   init, exp_increase, exp_decrease : single-cycle command pulses
// master : the side that owns the buttons and consumes the pulses
// slave  : the conditioner itself
interface button_conditioner_if;
  logic btn_init;
  logic btn_inc;
  logic btn_dec;
  logic init;
  logic exp_increase;
  logic exp_decrease;

  modport master (
    output btn_init, btn_inc, btn_dec,
    input  init, exp_increase, exp_decrease
  );

  modport slave (
    input  btn_init, btn_inc, btn_dec,
    output init, exp_increase, exp_decrease
  );
endinterface

// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes and debounces three raw push buttons and
// turns each press (stable 0->1) into a single-cycle command pulse.
// Priority on simultaneous events: init > exp_increase > exp_decrease.
// inc/dec pulses are suppressed while both of those buttons are held.
// Optional auto-repeat for inc/dec is compiled in with macro AUTO_REPEAT_EN.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : button_conditioner_if.slave (raw buttons in, pulses out)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int unsigned CW  = 8;
  localparam int unsigned NCH = 3;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reject illegal configurations at elaboration
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_DELAY < 2 || REPEAT_DELAY > 255 ||
      REPEAT_PERIOD < 2 || REPEAT_PERIOD > 255) begin : g_param_check
    $error("button_conditioner: parameters must lie in 2..255");
  end

  // Channel order: [0] init, [1] inc, [2] dec
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_d;
  logic [CW-1:0]  db_cnt [NCH];
  logic [NCH-1:0] press;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] pulse_next;
  logic           both_held;
  logic           inc_go;
  logic           dec_go;

  assign raw = {bus.btn_dec, bus.btn_inc, bus.btn_init};

  // Synchronizers and per-channel debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press detection, priority and inc/dec mutual inhibit
  assign press     = stable & ~stable_d;
  assign both_held = stable[1] & stable[2];
  assign inc_go    = press[1] & ~press[0] & ~both_held;
  assign dec_go    = press[2] & ~press[0] & ~press[1] & ~both_held;

`ifdef AUTO_REPEAT_EN
  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CW-1:0] RPT_FIRST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RPT_NEXT  = CW'(REPEAT_PERIOD - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] rpt_cnt;
  logic [CW-1:0] rpt_cnt_next;
  logic          held_dec;
  logic          held_dec_next;
  logic          held_level;
  logic          rpt_fire;

  assign held_level = held_dec ? stable[2] : stable[1];
  // Down-counter reaching zero marks the edge of the next repeat pulse
  assign rpt_fire   = (state == HOLD) && !press[0] && !both_held &&
                      held_level && (rpt_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (inc_go || dec_go) state_next = HOLD;
      HOLD: begin
        if (press[0])                        state_next = IDLE;
        else if (inc_go || dec_go)           state_next = HOLD;
        else if (both_held || !held_level)   state_next = IDLE;
        else                                 state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: pulse selection and repeat counter update
  always_comb begin
    pulse_next    = {dec_go, inc_go, press[0]};
    rpt_cnt_next  = rpt_cnt;
    held_dec_next = held_dec;
    if (inc_go || dec_go) begin
      // A fresh press (re)starts the repeat timer for that button
      rpt_cnt_next  = RPT_FIRST;
      held_dec_next = dec_go;
    end else if (state_next == IDLE) begin
      rpt_cnt_next  = '0;
    end else if (rpt_fire) begin
      pulse_next[1] = ~held_dec;
      pulse_next[2] = held_dec;
      rpt_cnt_next  = RPT_NEXT;
    end else begin
      rpt_cnt_next  = rpt_cnt - CW'(1);
    end
  end

  // Repeat counter and held-button registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt  <= '0;
      held_dec <= 1'b0;
    end else begin
      rpt_cnt  <= rpt_cnt_next;
      held_dec <= held_dec_next;
    end
  end
`else
  // Single pulse per press, no repeat
  always_comb begin
    pulse_next = {dec_go, inc_go, press[0]};
  end
`endif

  // Registered command pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse <= '0;
    else      pulse <= pulse_next;
  end

  assign bus.init         = pulse[0];
  assign bus.exp_increase = pulse[1];
  assign bus.exp_decrease = pulse[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4). The stimulus process pushes the cycle and
// output pattern of every expected pulse; the monitor pops on each pulse.
// Cycle numbering: cyc counts rising edges; a pulse following edge N is
// observed at the falling edge where cyc == N.
module tb_button_conditioner;

  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 8;
  localparam int unsigned RP  = 4;
  localparam int unsigned LAT = DB + 3;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   done;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [2:0] outs;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  assign outs = {bif.exp_decrease, bif.exp_increase, bif.init};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reset check, pulse scoreboard, end-of-run summary
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp = n_cmp + 1;
      if (outs != 3'b000) begin
        n_bad = n_bad + 1;
        $display("FAIL reset_outputs cyc=%0d got=%b want=000", cyc, outs);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL missed_pulse cyc=%0d got=none want=%b@%0d",
                 cyc, mon_e.val, mon_e.cyc);
      end
      if (outs != 3'b000) begin
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, outs);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.val != outs) begin
            n_bad = n_bad + 1;
            $display("FAIL pulse cyc=%0d got=%b want=%b@%0d",
                     cyc, outs, mon_e.val, mon_e.cyc);
          end
        end
      end
    end
    if (done) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
        n_bad = n_bad + 1;
        $display("FAIL leftover_expect got=%0d pending want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic [2:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  initial begin
    int b;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    done  = 1'b0;
    rst   = 1'b1;
    bif.btn_init = 1'b0;
    bif.btn_inc  = 1'b0;
    bif.btn_dec  = 1'b0;
    #2 rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);

    // Single inc press: one pulse LAT edges after first sample
    b = cyc;
    bif.btn_inc = 1'b1;
    expect_at(b + LAT, 3'b010);
    tick(6);
    bif.btn_inc = 1'b0;
    tick(12);

    // init glitches of 2 and 3 cycles: no pulse
    bif.btn_init = 1'b1;
    tick(2);
    bif.btn_init = 1'b0;
    tick(10);
    bif.btn_init = 1'b1;
    tick(3);
    bif.btn_init = 1'b0;
    tick(12);

    // init and dec together: init wins, dec discarded, no repeat
    b = cyc;
    bif.btn_init = 1'b1;
    bif.btn_dec  = 1'b1;
    expect_at(b + LAT, 3'b001);
    tick(30);
    bif.btn_init = 1'b0;
    bif.btn_dec  = 1'b0;
    tick(12);

    // dec held: first pulse, then repeats when compiled in
    b = cyc;
    bif.btn_dec = 1'b1;
    expect_at(b + LAT, 3'b100);
`ifdef AUTO_REPEAT_EN
    expect_at(b + LAT + 8,  3'b100);
    expect_at(b + LAT + 12, 3'b100);
    expect_at(b + LAT + 16, 3'b100);
    expect_at(b + LAT + 20, 3'b100);
    expect_at(b + LAT + 24, 3'b100);
    expect_at(b + LAT + 28, 3'b100);
`endif
    tick(31);
    bif.btn_dec = 1'b0;
    tick(14);

    // inc held, dec joins before the first repeat: nothing further
    b = cyc;
    bif.btn_inc = 1'b1;
    expect_at(b + LAT, 3'b010);
    tick(3);
    bif.btn_dec = 1'b1;
    tick(30);
    bif.btn_inc = 1'b0;
    bif.btn_dec = 1'b0;
    tick(14);

    // One-cycle inc glitch: no pulse
    bif.btn_inc = 1'b1;
    tick(1);
    bif.btn_inc = 1'b0;
    tick(10);

    // inc and dec raised together: mutually inhibited
    bif.btn_inc = 1'b1;
    bif.btn_dec = 1'b1;
    tick(12);
    bif.btn_inc = 1'b0;
    bif.btn_dec = 1'b0;
    tick(12);

    // Short dec press: one pulse
    b = cyc;
    bif.btn_dec = 1'b1;
    expect_at(b + LAT, 3'b100);
    tick(6);
    bif.btn_dec = 1'b0;
    tick(12);

    // init and inc together: only init
    b = cyc;
    bif.btn_init = 1'b1;
    bif.btn_inc  = 1'b1;
    expect_at(b + LAT, 3'b001);
    tick(6);
    bif.btn_init = 1'b0;
    bif.btn_inc  = 1'b0;
    tick(12);

    // Reset mid-debounce with inc held: partial count lost, fresh press later
    bif.btn_inc = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    rst = 1'b1;
    b = cyc;
    expect_at(b + LAT, 3'b010);
    tick(6);
    bif.btn_inc = 1'b0;
    tick(12);

    done = 1'b1;
    tick(4);
    $display("FAIL monitor_end got=running want=finished");
    $fatal(1, "monitor did not finish");
  end

endmodule
